// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

    localparam int DEFAULT_N = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Launch/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(parameter int N = 8);

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] diff;
    logic         borrow;
    logic         busy;
    logic         done;

    modport master (output start, A, B, input diff, borrow, busy, done);
    modport slave  (input start, A, B, output diff, borrow, busy, done);

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one full-subtractor cell and a registered borrow.
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | processing one bit pair per edge
//   DONE  | diff/borrow freshly valid, done pulse; start here relaunches
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                clk,
    input  logic                resetn,
    serial_subtractor_if.slave  sub_if
);

    localparam int              CW       = $clog2(N);
    localparam logic [CW-1:0]   LAST_BIT = CW'(N - 1);

    sub_state_t     state_q, state_d;
    logic [N-1:0]   a_sr_q, a_sr_d;
    logic [N-1:0]   b_sr_q, b_sr_d;
    logic [N-1:0]   res_q, res_d;
    logic           bin_q, bin_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           borrow_q, borrow_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           bit_d;
    logic           bit_bout;

    full_subtractor u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (bin_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (sub_if.start) begin
                    a_sr_d  = sub_if.A;
                    b_sr_d  = sub_if.B;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = {bit_d, res_q[N-1:1]};
                bin_d  = bit_bout;
                if (cnt_q == LAST_BIT) begin
                    // counter parks at the terminal count rather than wrapping
                    diff_d   = {bit_d, res_q[N-1:1]};
                    borrow_d = bit_bout;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sub_if.diff   = diff_q;
    assign sub_if.borrow = borrow_q;
    assign sub_if.busy   = busy_q;
    assign sub_if.done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at N=8 and N=5.
module tb_serial_subtractor;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.N(8)) if8 ();
    serial_subtractor_if #(.N(5)) if5 ();

    serial_subtractor #(.N(8)) dut8 (.clk(clk), .resetn(resetn), .sub_if(if8.slave));
    serial_subtractor #(.N(5)) dut5 (.clk(clk), .resetn(resetn), .sub_if(if5.slave));

    int tests  = 0;
    int failed = 0;

    logic [8:0] last8 = '0;
    logic [5:0] last5 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if8.start = 1'b1;
        if8.A     = a;
        if8.B     = b;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        if8.A     = ~a;
        if8.B     = ~b;
    endtask

    task automatic wait_done8(input string tag, output int edges, output int busy_cnt);
        bit got;
        got      = 1'b0;
        edges    = 0;
        busy_cnt = (if8.busy === 1'b1) ? 1 : 0;
        while (!got && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (if8.busy === 1'b1) busy_cnt++;
            if (if8.done === 1'b1) got = 1'b1;
            else chk({tag, " hold"}, {if8.borrow, if8.diff}, last8);
        end
        chk({tag, " done seen"}, got, 1);
    endtask

    task automatic finish8(input string tag, input logic [7:0] ed, input logic eb);
        chk({tag, " diff"}, if8.diff, ed);
        chk({tag, " borrow"}, if8.borrow, eb);
        last8 = {eb, ed};
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input string tag);
        int e, bc;
        logic [7:0] ed;
        ed = a - b;
        launch8(a, b);
        wait_done8(tag, e, bc);
        chk({tag, " latency"}, e, 8);
        finish8(tag, ed, a < b);
        @(posedge clk);
        #1;
        chk({tag, " done one cycle"}, if8.done, 0);
        chk({tag, " busy low"}, if8.busy, 0);
        chk({tag, " busy cycles"}, bc, 9);
    endtask

    task automatic do_op5(input logic [4:0] a, input logic [4:0] b, input string tag);
        int e;
        bit got;
        logic [4:0] ed;
        ed  = a - b;
        e   = 0;
        got = 1'b0;
        @(negedge clk);
        if5.start = 1'b1;
        if5.A     = a;
        if5.B     = b;
        @(posedge clk);
        #1;
        if5.start = 1'b0;
        if5.A     = ~a;
        if5.B     = ~b;
        while (!got && e < 20) begin
            @(posedge clk);
            #1;
            e++;
            if (if5.done === 1'b1) got = 1'b1;
            else chk({tag, " hold"}, {if5.borrow, if5.diff}, last5);
        end
        chk({tag, " done seen"}, got, 1);
        chk({tag, " latency"}, e, 5);
        chk({tag, " diff"}, if5.diff, ed);
        chk({tag, " borrow"}, if5.borrow, a < b);
        last5 = {a < b, ed};
    endtask

    initial begin
        int e, bc;
        logic [7:0] ra, rb;
        logic [4:0] sa, sb;

        if8.start = 1'b0; if8.A = '0; if8.B = '0;
        if5.start = 1'b0; if5.A = '0; if5.B = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset diff8",   if8.diff,   0);
        chk("reset borrow8", if8.borrow, 0);
        chk("reset busy8",   if8.busy,   0);
        chk("reset done8",   if8.done,   0);
        chk("reset diff5",   if5.diff,   0);
        chk("reset busy5",   if5.busy,   0);
        @(negedge clk);
        resetn = 1'b1;

        do_op8(8'hFF, 8'hA1, "ff-a1");
        chk("ff-a1 expect", last8, 9'h05E);
        do_op8(8'hAF, 8'h71, "af-71");
        chk("af-71 expect", last8, 9'h03E);
        do_op8(8'h71, 8'hAF, "71-af");
        chk("71-af expect", last8, 9'h1C2);
        do_op8(8'h55, 8'h55, "55-55");
        do_op8(8'h00, 8'h01, "00-01");
        chk("00-01 expect", last8, 9'h1FF);
        do_op8(8'hFE, 8'h91, "fe-91");
        chk("fe-91 expect", last8, 9'h06D);

        // start pulsed mid-shift must not disturb the running operation
        launch8(8'hAF, 8'h71);
        repeat (3) @(posedge clk);
        @(negedge clk);
        if8.start = 1'b1;
        if8.A     = 8'h00;
        if8.B     = 8'hFF;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        chk("midshift busy", if8.busy, 1);
        wait_done8("midshift", e, bc);
        chk("midshift latency", e, 4);
        finish8("midshift", 8'h3E, 1'b0);

        // relaunch from DONE with no idle cycle
        @(negedge clk);
        if8.start = 1'b1;
        if8.A     = 8'h55;
        if8.B     = 8'h55;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        chk("b2b busy", if8.busy, 1);
        chk("b2b done low", if8.done, 0);
        wait_done8("b2b", e, bc);
        chk("b2b latency", e, 8);
        finish8("b2b", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b idle", if8.busy, 0);

        do_op8(8'hFE, 8'h91, "pre-abort");

        // reset mid-operation aborts with no done pulse
        launch8(8'h71, 8'hAF);
        repeat (4) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("abort diff",   if8.diff,   0);
        chk("abort borrow", if8.borrow, 0);
        chk("abort busy",   if8.busy,   0);
        chk("abort done",   if8.done,   0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("abort no done", if8.done, 0);
        end
        @(negedge clk);
        resetn = 1'b1;
        last8  = '0;
        last5  = '0;
        do_op8(8'h00, 8'h01, "post-abort");

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op8(ra, rb, "rand8");
        end

        do_op5(5'h1F, 5'h01, "n5 1f-01");
        do_op5(5'h00, 5'h01, "n5 00-01");
        do_op5(5'h0A, 5'h0A, "n5 0a-0a");
        for (int i = 0; i < 200; i++) begin
            sa = 5'($urandom);
            sb = 5'($urandom);
            do_op5(sa, sb, "rand5");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
